ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter UUID, default 0, instance identifier XORed into child UUIDs.
REQ-002 Parameter NAME, default "", instance label.
REQ-003 Parameter MAX_WAIT, default 4, legal 1..15, cycles a debug request may be starved before forced grant.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cpu_load / cpu_save  input  1 each  CPU read / write request.
REQ-007 cpu_addr / cpu_wdata  input  8 each  CPU address / write data.
REQ-008 cpu_rdata  output  8  CPU read data; 0 when CPU not serviced.
REQ-009 cpu_stall  output  1  CPU access refused this cycle; holds the program counter.
REQ-010 dbg_req / dbg_we  input  1 each  debug request / write-not-read.
REQ-011 dbg_addr / dbg_wdata  input  8 each  debug address / write data.
REQ-012 dbg_gnt  output  1  debug access performed this cycle.
REQ-013 dbg_rdata / dbg_rvalid  output  8 / 1  registered debug read data and strobe.
REQ-014 ram_load / ram_save  output  1 each  to 256x8 RAM.
REQ-015 ram_addr / ram_wdata  output  8 each  to RAM.
REQ-016 ram_rdata  input  8  RAM read data, combinational from ram_addr/ram_load.

Function
REQ-017 cpu_active = cpu_load OR cpu_save.
REQ-018 FSM states IDLE, PENDING, RESP; IDLE->PENDING on dbg_req not granted; PENDING->IDLE on dbg_req drop; any->RESP after a granted debug read; RESP->IDLE/PENDING next cycle per dbg_req.
REQ-019 Debug grant (dbg_gnt=1, combinational) when dbg_req AND (NOT cpu_active OR wait_cnt==MAX_WAIT).
REQ-020 Granted cycle: ram_addr=dbg_addr, ram_wdata=dbg_wdata, ram_save=dbg_we, ram_load=NOT dbg_we; cpu_stall=cpu_active; cpu_rdata=0.
REQ-021 Non-granted cycle: RAM signals mirror CPU inputs exactly; cpu_rdata=ram_rdata when cpu_load else 0; cpu_stall=0.
REQ-022 cpu_load and cpu_save together pass through unchanged (read old data, write at edge).
REQ-023 wait_cnt (4 bit): +1 each cycle dbg_req high and not granted, saturating at MAX_WAIT; cleared on grant or dbg_req low.
REQ-024 Forced grant clears wait_cnt, so CPU owns at least MAX_WAIT consecutive cycles before next forced grant.
REQ-025 Granted read: dbg_rdata<=ram_rdata, dbg_rvalid=1 for exactly the following cycle; dbg_rdata holds until next granted read.
REQ-026 Granted write: no dbg_rvalid.
REQ-027 Back-to-back debug grants with CPU idle: one access per cycle, rvalid pipelined one cycle behind each read.
REQ-028 Zero-latency CPU path: no added register between CPU and RAM.

Reset
REQ-029 On rst: FSM=IDLE, wait_cnt=0, dbg_rvalid=0, dbg_rdata=0, stall_count=0; pending response discarded.
REQ-030 During rst cycle combinational outputs still follow REQ-019..021 with wait_cnt=0.

Configuration
REQ-031 Macro RAM_ARB_STATS_EN defined: output stall_count (8 bit) increments each cycle cpu_stall=1, saturates at 255, cleared by rst.
REQ-032 Macro undefined: no stall_count port, no counter logic; all other behaviour identical.

Verification
REQ-033 CPU idle, dbg read addr 0x10 holding 0x5A -> dbg_gnt same cycle, next cycle dbg_rvalid=1, dbg_rdata=0x5A.
REQ-034 CPU cpu_load every cycle, dbg_req held, MAX_WAIT=4 -> dbg_gnt and cpu_stall on 5th cycle only, then 4 CPU cycles before next grant.
REQ-035 CPU write 0x33 to 0x20 with cpu_load same address -> cpu_rdata old value, next read returns 0x33.
REQ-036 rst asserted in cycle after granted read -> dbg_rvalid=0, dbg_rdata=0, wait_cnt=0.
REQ-037 RAM_ARB_STATS_EN, 300 forced stalls -> stall_count=255; without macro, build has no stall_count port.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bundles the CPU, debug and RAM-side signals of the RAM port arbiter.
// The arbiter takes the slave view (serves CPU/debug, drives the RAM).
// The environment (CPU core, debug unit, RAM model) takes the master view.
interface ram_port_arbiter_if;
  // CPU side
  logic       cpu_load;
  logic       cpu_save;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  // Debug side
  logic       dbg_req;
  logic       dbg_we;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic       dbg_gnt;
  logic [7:0] dbg_rdata;
  logic       dbg_rvalid;
  // RAM side
  logic       ram_load;
  logic       ram_save;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  modport slave (
    input  cpu_load, cpu_save, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output ram_load, ram_save, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_load, cpu_save, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  ram_load, ram_save, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one 256x8 RAM port between a CPU and a debug unit; CPU has priority.
// Latency: CPU path and debug grant are combinational; debug read data arrives one cycle after grant.
// Backpressure: debug waits while the CPU is busy, but is force-granted after MAX_WAIT starved cycles (CPU is stalled then).
// Optional feature: define RAM_ARB_STATS_EN to add the saturating 8-bit stall_count output.
module ram_port_arbiter #(
  parameter int    UUID     = 0,
  parameter string NAME     = "",
  parameter int    MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  ram_port_arbiter_if.slave   bus
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [7:0]          stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] wait_eff;
  logic [7:0] dbg_rdata_q;
  logic       cpu_active;
  logic       gnt;

  assign cpu_active = bus.cpu_load | bus.cpu_save;
  // The reset cycle arbitrates as if nothing had been starved yet.
  assign wait_eff   = rst ? 4'd0 : wait_cnt;
  assign gnt        = bus.dbg_req & (~cpu_active | (wait_eff == WAIT_LIMIT));

  assign bus.dbg_gnt    = gnt;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.dbg_rvalid = (state == RESP);

  // Steer the RAM port to the debug unit on grant, otherwise pass the CPU straight through.
  always_comb begin
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    bus.ram_save  = bus.cpu_save;
    bus.ram_load  = bus.cpu_load;
    bus.cpu_stall = 1'b0;
    bus.cpu_rdata = bus.cpu_load ? bus.ram_rdata : 8'h00;
    if (gnt) begin
      bus.ram_addr  = bus.dbg_addr;
      bus.ram_wdata = bus.dbg_wdata;
      bus.ram_save  = bus.dbg_we;
      bus.ram_load  = ~bus.dbg_we;
      bus.cpu_stall = cpu_active;
      bus.cpu_rdata = 8'h00;
    end
  end

  // Debug-side FSM: tracks starvation, captures granted read data and raises rvalid one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      dbg_rdata_q <= 8'h00;
    end else begin
      if (gnt && !bus.dbg_we) begin
        state       <= RESP;
        dbg_rdata_q <= bus.ram_rdata;
      end else if (bus.dbg_req && !gnt) begin
        state <= PENDING;
      end else begin
        state <= IDLE;
      end

      if (gnt || !bus.dbg_req) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

`ifdef RAM_ARB_STATS_EN
  // Count cycles in which the CPU was refused, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= 8'd0;
    end else if (bus.cpu_stall && stall_count != 8'hFF) begin
      stall_count <= stall_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter with an in-bench reference model and a RAM model.
module tb_ram_port_arbiter;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_port_arbiter_if bus();

`ifdef RAM_ARB_STATS_EN
  logic [7:0] stall_count;
`endif

  ram_port_arbiter #(
    .UUID(0),
    .NAME("tb"),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RAM_ARB_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  // RAM model: combinational read, write at the rising edge.
  logic [7:0] mem [256];
  assign bus.ram_rdata = bus.ram_load ? mem[bus.ram_addr] : 8'h00;
  always @(posedge clk) if (bus.ram_save) mem[bus.ram_addr] <= bus.ram_wdata;

  // Reference model state.
  logic [7:0] ref_mem [256];
  int         m_starve;
  bit         m_rvalid;
  logic [7:0] m_rdata;
  int         m_stalls;
  bit         m_known;

  int n_chk;
  int n_pass;
  int cyc;

  // Values observed in the most recent cycle, for the hand-computed expectations.
  logic       obs_gnt, obs_stall, obs_rv;
  logic [7:0] obs_crd, obs_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: actual %0h required %0h", name, cyc, act, exp);
  endtask

  // Drive one cycle of stimulus, compare everything against the model, then advance the model.
  task automatic run_cycle(input bit r, input bit cl, input bit cs,
                           input logic [7:0] ca, input logic [7:0] cw,
                           input bit dr, input bit dw,
                           input logic [7:0] da, input logic [7:0] dd);
    bit         busy, e_gnt, e_save, e_load, e_stall;
    logic [7:0] e_addr, e_wd, e_crd, nxt_rd;
    int         starve_now;
    bit         nxt_rv;
    @(negedge clk);
    rst = r;
    bus.cpu_load = cl; bus.cpu_save = cs; bus.cpu_addr = ca; bus.cpu_wdata = cw;
    bus.dbg_req = dr;  bus.dbg_we = dw;   bus.dbg_addr = da; bus.dbg_wdata = dd;
    #1;
    busy       = cl | cs;
    starve_now = r ? 0 : m_starve;
    e_gnt      = dr && (!busy || starve_now >= MAX_WAIT);
    if (e_gnt) begin
      e_addr = da; e_wd = dd; e_save = dw; e_load = !dw; e_stall = busy; e_crd = 8'h00;
    end else begin
      e_addr = ca; e_wd = cw; e_save = cs; e_load = cl; e_stall = 1'b0;
      e_crd = cl ? ref_mem[ca] : 8'h00;
    end
    chk("dbg_gnt",   32'(bus.dbg_gnt),   32'(e_gnt));
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
    chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_crd));
    chk("ram_addr",  32'(bus.ram_addr),  32'(e_addr));
    chk("ram_wdata", 32'(bus.ram_wdata), 32'(e_wd));
    chk("ram_load",  32'(bus.ram_load),  32'(e_load));
    chk("ram_save",  32'(bus.ram_save),  32'(e_save));
    if (m_known) begin
      chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(m_rvalid));
      chk("dbg_rdata",  32'(bus.dbg_rdata),  32'(m_rdata));
`ifdef RAM_ARB_STATS_EN
      chk("stall_count", 32'(stall_count), 32'(m_stalls));
`endif
    end
    obs_gnt = bus.dbg_gnt; obs_stall = bus.cpu_stall; obs_crd = bus.cpu_rdata;
    obs_rv = bus.dbg_rvalid; obs_rd = bus.dbg_rdata;
    @(posedge clk);
    cyc++;
    if (e_gnt && !dw) begin nxt_rv = 1'b1; nxt_rd = ref_mem[da]; end
    else begin nxt_rv = 1'b0; nxt_rd = m_rdata; end
    if (e_save) ref_mem[e_addr] = e_wd;
    if (r) begin
      m_rvalid = 1'b0; m_rdata = 8'h00; m_starve = 0; m_stalls = 0; m_known = 1'b1;
    end else begin
      m_rvalid = nxt_rv;
      m_rdata  = nxt_rd;
      if (dr && !e_gnt) m_starve = (m_starve + 1 > MAX_WAIT) ? MAX_WAIT : m_starve + 1;
      else m_starve = 0;
      if (e_stall && m_stalls < 255) m_stalls++;
    end
  endtask

  task automatic idle_cycle(input bit r);
    run_cycle(r, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, actual running required finished");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    m_starve = 0; m_rvalid = 1'b0; m_rdata = 8'h00; m_stalls = 0; m_known = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'hA5;
      ref_mem[i] = 8'(i) ^ 8'hA5;
    end
    mem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;

    // Reset and reset state.
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    chk("reset_rvalid", 32'(obs_rv), 32'd0);
    chk("reset_rdata",  32'(obs_rd), 32'd0);
    chk("reset_gnt",    32'(obs_gnt), 32'd0);

    // Debug read with CPU idle: grant now, data next cycle, then held.
    run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("lit_gnt_idle", 32'(obs_gnt), 32'd1);
    idle_cycle(1'b0);
    chk("lit_rvalid_next", 32'(obs_rv), 32'd1);
    chk("lit_rdata_next",  32'(obs_rd), 32'h5A);
    idle_cycle(1'b0);
    chk("lit_rvalid_once", 32'(obs_rv), 32'd0);
    chk("lit_rdata_hold",  32'(obs_rd), 32'h5A);

    // Simultaneous load+save: old data now, new data on the next read.
    run_cycle(1'b0, 1'b1, 1'b1, 8'h20, 8'h33, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("lit_rw_old", 32'(obs_crd), 32'h85);
    run_cycle(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("lit_rw_new", 32'(obs_crd), 32'h33);

    // Back-to-back debug reads with CPU idle.
    run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    chk("lit_b2b_gnt",  32'(obs_gnt), 32'd1);
    chk("lit_b2b_rd0",  32'(obs_rd),  32'h5A);
    idle_cycle(1'b0);
    chk("lit_b2b_rv1",  32'(obs_rv),  32'd1);
    chk("lit_b2b_rd1",  32'(obs_rd),  32'h33);

    // Starve the debug unit to the limit, then reset: the reset cycle must not force a grant.
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00);
      chk("lit_starve_nognt", 32'(obs_gnt), 32'd0);
    end
    run_cycle(1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00);
    chk("lit_rst_nognt", 32'(obs_gnt), 32'd0);

    // Continuous CPU loads with debug held: forced grant on every 5th cycle.
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 1'b0, 8'h30, 8'h00);
      chk("lit_forced_gnt",   32'(obs_gnt),   32'((i == 4) || (i == 9)));
      chk("lit_forced_stall", 32'(obs_stall), 32'((i == 4) || (i == 9)));
    end

    // Reset right after a granted read discards the response.
    idle_cycle(1'b1);
    chk("lit_rst_cycle_rv", 32'(obs_rv), 32'd1);
    chk("lit_rst_cycle_rd", 32'(obs_rd), 32'h95);
    idle_cycle(1'b0);
    chk("lit_after_rst_rv", 32'(obs_rv), 32'd0);
    chk("lit_after_rst_rd", 32'(obs_rd), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      run_cycle($urandom_range(0, 99) == 0,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 4) == 0,
                8'($urandom_range(0, 15)), 8'($urandom),
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 2) == 0,
                8'($urandom_range(0, 15)), 8'($urandom));
    end

`ifdef RAM_ARB_STATS_EN
    // Enough forced stalls to saturate the counter.
    idle_cycle(1'b1);
    for (int i = 0; i < 1600; i++)
      run_cycle(1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h06, 8'h00);
    idle_cycle(1'b0);
    chk("lit_stall_sat", 32'(stall_count), 32'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
